// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: pipeline condition inputs and the control outputs
// that gate and flush the five pipeline registers.
interface hazard_unit_if;
  // All signals are plain levels sampled every cycle. There is no valid/ready
  // pair: the pipeline holds its condition inputs stable for the cycle, and
  // the hazard unit answers combinationally within that same cycle.
  logic       ihit;
  logic       dmemreq;
  logic       dhit;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       branch_taken;
  logic       exmem_halt;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halted;

  modport master (
    output ihit, dmemreq, dhit, idex_memread, idex_rt, ifid_rs, ifid_rt,
           ifid_uses_rt, branch_taken, exmem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, halted
  );

  modport slave (
    input  ihit, dmemreq, dhit, idex_memread, idex_rt, ifid_rs, ifid_rt,
           ifid_uses_rt, branch_taken, exmem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, halted
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: resolves halt, data-memory wait, branch redirect,
// load-use and fetch-wait conditions into register enables and flushes.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  hazard_unit_if.slave     hu,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic load_use;
  logic resolve, allow_lu, allow_dmem;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush;

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = hu.idex_memread && (hu.idex_rt != 5'd0) &&
                    ((hu.idex_rt == hu.ifid_rs) ||
                     (hu.ifid_uses_rt && (hu.idex_rt == hu.ifid_rt)));

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    resolve    = 1'b0;
    allow_lu   = 1'b0;
    allow_dmem = 1'b0;

    // RUN, LDUSE and the completing DWAIT cycle share one priority resolver;
    // they differ only in which conditions are allowed to participate.
    if (nRST) begin
      unique case (state)
        RUN:   begin resolve = 1'b1; allow_lu = 1'b1; allow_dmem = 1'b1; end
        LDUSE: begin resolve = 1'b1; allow_dmem = 1'b1; end
        DWAIT: if (hu.dhit) begin resolve = 1'b1; allow_lu = 1'b1; end
        HALT:  ;
      endcase
    end

    if (resolve) begin
      if (hu.exmem_halt) begin
        state_nxt = HALT;
      end else if (allow_dmem && hu.dmemreq && !hu.dhit) begin
        state_nxt = DWAIT;
      end else if (hu.branch_taken) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_nxt  = RUN;
      end else if (allow_lu && load_use) begin
        {idex_en, exmem_en, memwb_en} = 3'b111;
        idex_flush = 1'b1;
        state_nxt  = LDUSE;
      end else if (!hu.ihit) begin
        {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
        ifid_flush = 1'b1;
        state_nxt  = RUN;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        state_nxt = RUN;
      end
    end
  end

  assign hu.pc_en      = pc_en;
  assign hu.ifid_en    = ifid_en;
  assign hu.idex_en    = idex_en;
  assign hu.exmem_en   = exmem_en;
  assign hu.memwb_en   = memwb_en;
  assign hu.ifid_flush = ifid_flush;
  assign hu.idex_flush = idex_flush;
  assign hu.halted     = (state == HALT);
  assign state_dbg     = state;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Saturates so a long stall never wraps back to a small count.
      if (!pc_en && (state != HALT) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table of single-cycle vectors from RUN,
// plus multi-cycle sequences for load-use, dmem wait, halt, reset and saturation.
module tb_hazard_unit;

  localparam logic [7:0] O_NORM  = 8'hF8;
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_BR    = 8'hFE;
  localparam logic [7:0] O_LU    = 8'h3A;
  localparam logic [7:0] O_FETCH = 8'h7C;
  localparam logic [7:0] O_HALT  = 8'h01;

  localparam logic [1:0] S_RUN = 2'd0, S_LDUSE = 2'd1, S_DWAIT = 2'd2, S_HALT = 2'd3;

  typedef struct {
    logic       ihit, dmemreq, dhit, memread;
    logic [4:0] idex_rt, rs, rt;
    logic       uses_rt, br, halt;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic        CLK;
  logic        nRST;
  logic [15:0] stall_cnt;
  logic [3:0]  sat_cnt;
  logic [1:0]  state_dbg, sat_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  hazard_unit_if hu_if ();
  hazard_unit_if sat_if ();

  hazard_unit dut (
    .CLK(CLK), .nRST(nRST), .hu(hu_if.slave),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  hazard_unit #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .hu(sat_if.slave),
    .stall_cnt(sat_cnt), .state_dbg(sat_state)
  );

  assign sat_if.ihit         = hu_if.ihit;
  assign sat_if.dmemreq      = hu_if.dmemreq;
  assign sat_if.dhit         = hu_if.dhit;
  assign sat_if.idex_memread = hu_if.idex_memread;
  assign sat_if.idex_rt      = hu_if.idex_rt;
  assign sat_if.ifid_rs      = hu_if.ifid_rs;
  assign sat_if.ifid_rt      = hu_if.ifid_rt;
  assign sat_if.ifid_uses_rt = hu_if.ifid_uses_rt;
  assign sat_if.branch_taken = hu_if.branch_taken;
  assign sat_if.exmem_halt   = hu_if.exmem_halt;

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(logic ihit, logic dmemreq, logic dhit, logic memread,
                             logic [4:0] idex_rt, logic [4:0] rs, logic [4:0] rt,
                             logic uses_rt, logic br, logic halt);
    in_t v;
    v.ihit = ihit; v.dmemreq = dmemreq; v.dhit = dhit; v.memread = memread;
    v.idex_rt = idex_rt; v.rs = rs; v.rt = rt;
    v.uses_rt = uses_rt; v.br = br; v.halt = halt;
    return v;
  endfunction

  function automatic in_t rand_in();
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
  endfunction

  // Driver tasks
  task automatic drive(input in_t v);
    hu_if.ihit         = v.ihit;
    hu_if.dmemreq      = v.dmemreq;
    hu_if.dhit         = v.dhit;
    hu_if.idex_memread = v.memread;
    hu_if.idex_rt      = v.idex_rt;
    hu_if.ifid_rs      = v.rs;
    hu_if.ifid_rt      = v.rt;
    hu_if.ifid_uses_rt = v.uses_rt;
    hu_if.branch_taken = v.br;
    hu_if.exmem_halt   = v.halt;
  endtask

  function automatic logic [7:0] outs();
    return {hu_if.pc_en, hu_if.ifid_en, hu_if.idex_en, hu_if.exmem_en, hu_if.memwb_en,
            hu_if.ifid_flush, hu_if.idex_flush, hu_if.halted};
  endfunction

  // Scoreboard
  task automatic check_out(input string tag, input logic [7:0] mask);
    logic [7:0] e, a;
    e = exp_q.pop_front();
    a = outs() & mask;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", tag, a, e);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input in_t v, input logic [7:0] e, input string tag);
    drive(v);
    exp_q.push_back(e);
    @(negedge CLK);
    check_out(tag, 8'hFF);
    @(posedge CLK);
    #1;
  endtask

  // Outputs other than halted must be quiet while nRST is low, from any state.
  task automatic do_reset(input string tag);
    nRST = 1'b0;
    drive(rand_in());
    exp_q.push_back(O_NONE);
    @(negedge CLK);
    check_out(tag, 8'hFE);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  vec_t tbl[14];
  in_t  idle, lu_in, fw_in, dw_in;

  initial begin
    idle  = mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    lu_in = mk(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    fw_in = mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    dw_in = mk(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    tbl[0]  = '{mk(1, 0, 0, 0, 5'd3, 5'd4, 5'd6, 1, 0, 0), O_NORM};
    tbl[1]  = '{mk(1, 0, 0, 1, 5'd5, 5'd5, 5'd7, 0, 0, 0), O_LU};
    tbl[2]  = '{mk(1, 0, 0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0), O_LU};
    tbl[3]  = '{mk(1, 0, 0, 1, 5'd9, 5'd2, 5'd9, 0, 0, 0), O_NORM};
    tbl[4]  = '{mk(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0), O_NORM};
    tbl[5]  = '{mk(1, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 0, 0), O_NORM};
    tbl[6]  = '{mk(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0), O_BR};
    tbl[7]  = '{fw_in, O_FETCH};
    tbl[8]  = '{dw_in, O_NONE};
    tbl[9]  = '{mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM};
    tbl[10] = '{mk(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1), O_NONE};
    tbl[11] = '{mk(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_NONE};
    tbl[12] = '{mk(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0), O_LU};
    tbl[13] = '{mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_BR};

    nRST = 1'b0;
    drive(idle);
    @(posedge CLK);
    #1;

    // Reset state
    do_reset("reset_outputs");
    check_val("reset_stall_cnt", 32'(stall_cnt), 0);
    check_val("reset_halted", 32'(hu_if.halted), 0);
    check_val("reset_state", 32'(state_dbg), S_RUN);

    // Single-cycle vectors from RUN
    for (int i = 0; i < 14; i++) begin
      do_reset("tbl_reset");
      step(tbl[i].in, tbl[i].exp, $sformatf("tbl[%0d]", i));
    end

    // Load-use: exactly one bubble, then normal with the same inputs
    do_reset("lu_reset");
    step(lu_in, O_LU, "lu_bubble");
    check_val("lu_state", 32'(state_dbg), S_LDUSE);
    step(lu_in, O_NORM, "lu_after");
    check_val("lu_stall_cnt", 32'(stall_cnt), 1);

    // Dmem wait: three stalled cycles, release on dhit
    do_reset("dw_reset");
    for (int i = 0; i < 3; i++) step(dw_in, O_NONE, $sformatf("dw_wait%0d", i));
    step(mk(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM, "dw_hit");
    check_val("dw_stall_cnt", 32'(stall_cnt), 3);

    // DWAIT ignores halt/branch until dhit; the dhit cycle still detects load-use
    do_reset("dw2_reset");
    step(dw_in, O_NONE, "dw2_enter");
    step(mk(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1), O_NONE, "dw2_hold");
    check_val("dw2_state", 32'(state_dbg), S_DWAIT);
    step(mk(1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0), O_LU, "dw2_hit_lu");
    check_val("dw2_state_lu", 32'(state_dbg), S_LDUSE);
    step(lu_in, O_NORM, "dw2_after");
    check_val("dw2_stall_cnt", 32'(stall_cnt), 3);

    // Branch over load-use: no LDUSE entry, so load-use fires on the next cycle
    do_reset("br_reset");
    step(mk(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0), O_BR, "br_lu");
    check_val("br_state", 32'(state_dbg), S_RUN);
    step(lu_in, O_LU, "br_next_lu");

    // LDUSE into dmem wait, then reset leaves no residual bubble
    do_reset("ld_reset");
    step(lu_in, O_LU, "ld_bubble");
    step(dw_in, O_NONE, "ld_dwait");
    check_val("ld_state", 32'(state_dbg), S_DWAIT);
    do_reset("ld_reset2");
    check_val("ld_state_after_reset", 32'(state_dbg), S_RUN);
    step(lu_in, O_LU, "ld_fresh_lu");

    // Halt: sticky, counter frozen, cleared only by reset
    do_reset("halt_reset");
    step(idle, O_NORM, "halt_pre");
    step(mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_NONE, "halt_enter");
    check_val("halt_state", 32'(state_dbg), S_HALT);
    for (int i = 0; i < 6; i++) step(rand_in(), O_HALT, $sformatf("halt_hold%0d", i));
    check_val("halt_stall_frozen", 32'(stall_cnt), 1);
    do_reset("halt_exit");
    check_val("halt_cleared", 32'(hu_if.halted), 0);
    check_val("halt_stall_cleared", 32'(stall_cnt), 0);
    step(idle, O_NORM, "halt_resume");

    // Saturation: 20 fetch-wait cycles on both widths
    do_reset("sat_reset");
    for (int i = 0; i < 20; i++) step(fw_in, O_FETCH, $sformatf("sat%0d", i));
    check_val("sat_wide_cnt", 32'(stall_cnt), 20);
    check_val("sat_narrow_cnt", 32'(sat_cnt), 15);

    check_val("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port CLK  input  1  pipeline clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ihit  input  1  instruction fetch complete this cycle.
REQ-005 SHALL have port dmemreq  input  1  EX/MEM holds a load or store.
REQ-006 SHALL have port dhit  input  1  data access complete this cycle.
REQ-007 SHALL have port idex_memread  input  1  ID/EX holds a load.
REQ-008 SHALL have port idex_rt  input  5  load destination register in ID/EX.
REQ-009 SHALL have ports ifid_rs, ifid_rt  input  5 each  source registers of the IF/ID instruction.
REQ-010 SHALL have port ifid_uses_rt  input  1  IF/ID instruction reads rt as an operand.
REQ-011 SHALL have port branch_taken  input  1  branch or jump redirect resolved in EX.
REQ-012 SHALL have port exmem_halt  input  1  HALT instruction in EX/MEM.
REQ-013 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables.
REQ-014 SHALL have ports ifid_flush, idex_flush  output  1 each  load a bubble (NOP) into the register.
REQ-015 SHALL have port halted  output  1  processor halted.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of cycles with pc_en=0 while not halted.

Function
REQ-017 SHALL implement FSM states RUN, LDUSE, DWAIT, HALT.
REQ-018 SHALL define load-use hazard = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
REQ-019 SHALL resolve conditions in RUN and LDUSE with fixed priority: exmem_halt > dmem wait (dmemreq && !dhit) > branch_taken > load-use (RUN only) > fetch wait (!ihit) > normal.
REQ-020 SHALL on exmem_halt: all enables 0, no flush, next state HALT.
REQ-021 SHALL on dmem wait: all five enables 0, no flush, next state DWAIT.
REQ-022 SHALL in DWAIT hold all enables 0 until dhit=1; the dhit cycle behaves exactly as RUN with dmemreq ignored, next state from that evaluation.
REQ-023 SHALL on branch_taken: pc_en=1, ifid_flush=1, idex_flush=1, all enables 1; a concurrent load-use is discarded.
REQ-024 SHALL on load-use: pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en/memwb_en=1, next state LDUSE.
REQ-025 SHALL in LDUSE suppress load-use detection for one cycle (exactly one bubble per load), then return to RUN.
REQ-026 SHALL on fetch wait: pc_en=0, ifid_flush=1, remaining enables 1.
REQ-027 SHALL in normal case drive all enables 1, flushes 0.
REQ-028 SHALL ensure flush outputs override enables (flushed register loads NOP regardless of its enable).
REQ-029 SHALL in HALT drive all enables 0, flushes 0, halted=1, remaining there until reset.
REQ-030 SHALL increment stall_cnt on each cycle with pc_en=0 and state not HALT, saturating at all-ones.

Reset
REQ-031 SHALL on rising CLK with nRST=0 set state RUN, stall_cnt 0, halted 0.
REQ-032 SHALL while nRST=0 drive all enables 0 and both flushes 0.
REQ-033 SHALL abandon any DWAIT, LDUSE or HALT on reset with no residual bubble.

Verification
REQ-034 SHALL verify load-use: idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, then normal; stall_cnt=1.
REQ-035 SHALL verify dmem wait: dmemreq=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, enables 1 on dhit cycle; stall_cnt=3.
REQ-036 SHALL verify branch over load-use: branch_taken=1 with load-use true -> pc_en=1, ifid_flush=1, idex_flush=1, no LDUSE entry.
REQ-037 SHALL verify zero register: idex_rt=0, ifid_rs=0, idex_memread=1 -> no stall.
REQ-038 SHALL verify halt: exmem_halt=1 -> halted=1 next cycle, enables 0 indefinitely, stall_cnt frozen; nRST=0 one cycle -> halted=0, stall_cnt=0.
REQ-039 SHALL verify saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=15.
